// File: rtl/dm_bridge.sv
// dm_bridge: M-stage data-memory bridge turning byte/half/word loads/stores into a word-addressed,
// byte-enabled req/ack access. Define DM_BRIDGE_TIMEOUT_EN to enable the ack watchdog.
module dm_bridge #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              timeout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic              tmo_hit;

    logic              req_misaligned;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata_rep;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_data;

    assign req_misaligned = (req_size == 2'd3)
                          || ((req_size == 2'd1) && req_addr[0])
                          || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    always_comb begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
        case (req_size)
            2'd0: begin
                req_be        = 4'b0001 << req_addr[1:0];
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select uses the offset latched at issue, not the live request.
    always_comb begin
        case (off_q)
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            2'd3:    lane_b = mem_rdata[31:24];
            default: lane_b = mem_rdata[7:0];
        endcase
        lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'd0:    load_data = {{24{sign_q & lane_b[7]}}, lane_b};
            2'd1:    load_data = {{16{sign_q & lane_h[15]}}, lane_h};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        size_d      = size_q;
        sign_d      = sign_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_misaligned) begin
                        state_d    = StDone;
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                    end else begin
                        state_d     = StWait;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_write;
                        mem_be_d    = req_be;
                        mem_addr_d  = req_addr[ADDR_W-1:2];
                        mem_wdata_d = req_wdata_rep;
                        size_d      = req_size;
                        sign_d      = req_sign;
                        off_d       = req_addr[1:0];
                    end
                end
            end
            StWait: begin
                if (mem_ack) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    rdata_d   = mem_we_q ? 32'h0 : load_data;
                end else if (tmo_hit) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    rdata_d   = '0;
                end
            end
            StDone: begin
                state_d    = StIdle;
                misalign_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            off_q       <= '0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
        end
    end

`ifdef DM_BRIDGE_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 256) ? $clog2(TIMEOUT) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tmo_q, tmo_d;

    // Counter is held at zero outside WAIT, so every WAIT entry starts from zero.
    assign tmo_hit = (state_q == StWait) && !mem_ack && (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = (state_q == StWait) ? cnt_q + 1'b1 : '0;
        tmo_d = tmo_q;
        if (tmo_hit) begin
            tmo_d = 1'b1;
        end else if (state_q == StDone) begin
            tmo_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT;
    assign tmo_hit            = 1'b0;
    assign timeout            = 1'b0;
`endif

    assign stall     = req_valid && (state_q != StDone);
    assign done      = (state_q == StDone);
    assign rdata     = rdata_q;
    assign misalign  = misalign_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_bridge.sv
// Self-checking bench for dm_bridge: directed scenarios plus randomized back-to-back accesses
// scored against a behavioural model of the access rules.
module tb_dm_bridge;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_write, req_sign;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          stall, done, misalign, timeout;
    logic [31:0]   rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [3:0]    mem_be;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    dm_bridge #(.ADDR_W(AW), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata), .misalign(misalign), .timeout(timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            done_cyc;
        int            stall_cnt;
        logic          stall_done;
        logic          req_seen;
        logic          req_at_done;
        logic          we;
        logic [3:0]    be;
        logic [AW-3:0] addr;
        logic [31:0]   wdata;
        logic          stable;
        logic [31:0]   rdata;
        logic          mis;
        logic          tmo;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic bit m_mis(logic [1:0] sz, logic [AW-1:0] a);
        int off = int'(a) % 4;
        return (sz == 2'd3) || (sz == 2'd1 && off % 2 == 1) || (sz == 2'd2 && off != 0);
    endfunction

    function automatic logic [3:0] m_be(logic [1:0] sz, logic [AW-1:0] a);
        int off = int'(a) % 4;
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return (off >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(logic [1:0] sz, logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(logic [1:0] sz, logic sg, logic [AW-1:0] a,
                                           logic [31:0] rd);
        int off = int'(a) % 4;
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (8 * off)) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- driver / memory responder ----------------
    // Cycle 0 is the first cycle the request is presented. Ack is given after `waits` cycles
    // of mem_req; mem_rdata carries junk outside the ack cycle.
    task automatic run_access(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [AW-1:0] ad, input logic [31:0] wd,
                              input logic [31:0] rd, input int waits, input bit flush,
                              output obs_t o);
        int seen = 0;
        o = '{default: 0};
        o.done_cyc = -1;
        o.stable   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_sign = sg;
        req_addr = ad; req_wdata = wd; mem_ack = 1'b0; mem_rdata = $urandom;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (flush) req_valid = 1'b0;
                mem_ack   = mem_req && (seen == waits);
                mem_rdata = mem_ack ? rd : $urandom;
                if (mem_req) seen++;
            end
            @(negedge clk);
            if (mem_req) begin
                if (!o.req_seen) begin
                    o.req_seen = 1'b1;
                    o.we = mem_we; o.be = mem_be; o.addr = mem_addr; o.wdata = mem_wdata;
                end else if ({mem_we, mem_be, mem_addr, mem_wdata} !==
                             {o.we, o.be, o.addr, o.wdata}) begin
                    o.stable = 1'b0;
                end
            end
            if (done) begin
                o.done_cyc = c; o.stall_done = stall; o.rdata = rdata;
                o.mis = misalign; o.tmo = timeout; o.req_at_done = mem_req;
                break;
            end
            if (stall) o.stall_cnt++;
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        req_valid = 1'b0; mem_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_sign = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        n_checks++;
        if ({mem_req, mem_we, done, misalign, timeout} !== 5'b0) begin
            $display("FAIL reset_flags: got %b want 00000", {mem_req, mem_we, done, misalign, timeout});
        end else n_pass++;
        n_checks++;
        if ({mem_be, mem_addr, mem_wdata, rdata} !== '0) begin
            $display("FAIL reset_data: got be=%h addr=%h wdata=%h rdata=%h want all 0",
                     mem_be, mem_addr, mem_wdata, rdata);
        end else n_pass++;
        #10 reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stall, done} !== 2'b00) begin
            $display("FAIL reset_idle_stall: got stall=%b done=%b want 0 0", stall, done);
        end else n_pass++;
    endtask

    task automatic test_word_store();
        obs_t o;
        run_access(1'b1, 2'd2, 1'b0, 14'h0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, o);
        n_checks++;
        if ({o.we, o.be, o.addr, o.wdata} !== {1'b1, 4'b1111, 12'h004, 32'hDEAD_BEEF}) begin
            $display("FAIL sw_request: got we=%b be=%b addr=%h wdata=%h want 1 1111 004 deadbeef",
                     o.we, o.be, o.addr, o.wdata);
        end else n_pass++;
        n_checks++;
        if (o.done_cyc !== 2 || o.stall_cnt !== 2 || o.stall_done !== 1'b0) begin
            $display("FAIL sw_timing: got done_cyc=%0d stall_cycles=%0d stall_at_done=%b want 2 2 0",
                     o.done_cyc, o.stall_cnt, o.stall_done);
        end else n_pass++;
        n_checks++;
        if ({o.rdata, o.mis, o.tmo, o.req_at_done} !== {32'h0, 3'b000}) begin
            $display("FAIL sw_completion: got rdata=%h mis=%b tmo=%b req=%b want 0 0 0 0",
                     o.rdata, o.mis, o.tmo, o.req_at_done);
        end else n_pass++;
        go_idle();
    endtask

    task automatic test_signed_byte_load();
        obs_t o;
        run_access(1'b0, 2'd0, 1'b1, 14'h0013, 32'h0, 32'h80FF_7F01, 3, 1'b0, o);
        n_checks++;
        if (o.be !== 4'b1000 || o.we !== 1'b0 || o.stable !== 1'b1) begin
            $display("FAIL lb_request: got be=%b we=%b stable=%b want 1000 0 1", o.be, o.we, o.stable);
        end else n_pass++;
        n_checks++;
        if (o.rdata !== 32'hFFFF_FF80 || o.done_cyc !== 5 || o.stall_cnt !== 5) begin
            $display("FAIL lb_result: got rdata=%h done_cyc=%0d stall_cycles=%0d want ffffff80 5 5",
                     o.rdata, o.done_cyc, o.stall_cnt);
        end else n_pass++;
        go_idle();
    endtask

    task automatic test_unsigned_half_load();
        obs_t o;
        run_access(1'b0, 2'd1, 1'b0, 14'h0006, 32'h0, 32'h9ABC_1234, 1, 1'b0, o);
        n_checks++;
        if (o.be !== 4'b1100 || o.addr !== 12'h001) begin
            $display("FAIL lhu_request: got be=%b addr=%h want 1100 001", o.be, o.addr);
        end else n_pass++;
        n_checks++;
        if (o.rdata !== 32'h0000_9ABC || o.done_cyc !== 3) begin
            $display("FAIL lhu_result: got rdata=%h done_cyc=%0d want 00009abc 3",
                     o.rdata, o.done_cyc);
        end else n_pass++;
        go_idle();
    endtask

    task automatic test_misalign();
        obs_t o;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) run_access(1'b0, 2'd2, 1'b0, 14'h0002, 32'h0, 32'h1111_1111, 0, 1'b0, o);
            else        run_access(1'b1, 2'd1, 1'b0, 14'h0001, 32'hCAFE, 32'h0, 0, 1'b0, o);
            n_checks++;
            if (o.req_seen !== 1'b0 || o.done_cyc !== 1 || o.stall_cnt !== 1) begin
                $display("FAIL misalign_%0d_timing: got req_seen=%b done_cyc=%0d stall_cycles=%0d want 0 1 1",
                         k, o.req_seen, o.done_cyc, o.stall_cnt);
            end else n_pass++;
            n_checks++;
            if (o.mis !== 1'b1 || o.rdata !== 32'h0) begin
                $display("FAIL misalign_%0d_flag: got misalign=%b rdata=%h want 1 0", k, o.mis, o.rdata);
            end else n_pass++;
        end
        go_idle();
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        int   bad = 0;
        logic [31:0] rd = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_sign = 1'b0;
        req_addr = 14'h0020; mem_ack = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (mem_req !== 1'b1) begin
            $display("FAIL rst_mid_req_up: got mem_req=%b want 1", mem_req);
        end else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, done} !== 2'b00) begin
            $display("FAIL rst_mid_async: got mem_req=%b done=%b want 0 0", mem_req, done);
        end else n_pass++;
        @(posedge clk); #3;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = $urandom;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || mem_req) bad++;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        n_checks++;
        if (bad !== 0) begin
            $display("FAIL rst_stale_ack: got %0d cycles with done/mem_req want 0", bad);
        end else n_pass++;
        run_access(1'b0, 2'd2, 1'b0, 14'h0024, 32'h0, rd, 1, 1'b0, o);
        n_checks++;
        if (o.rdata !== rd || o.done_cyc !== 3 || o.addr !== 12'h009) begin
            $display("FAIL rst_followup_lw: got rdata=%h done_cyc=%0d addr=%h want %h 3 009",
                     o.rdata, o.done_cyc, o.addr, rd);
        end else n_pass++;
        go_idle();
    endtask

    task automatic test_flush();
        obs_t o;
        run_access(1'b0, 2'd2, 1'b0, 14'h0040, 32'h0, 32'h1234_5678, 2, 1'b1, o);
        n_checks++;
        if (o.done_cyc !== 4 || o.rdata !== 32'h1234_5678) begin
            $display("FAIL flush_complete: got done_cyc=%0d rdata=%h want 4 12345678",
                     o.done_cyc, o.rdata);
        end else n_pass++;
        n_checks++;
        if (o.stall_cnt !== 1 || o.stall_done !== 1'b0) begin
            $display("FAIL flush_stall: got stall_cycles=%0d stall_at_done=%b want 1 0",
                     o.stall_cnt, o.stall_done);
        end else n_pass++;
        go_idle();
    endtask

    task automatic test_back_to_back();
        obs_t o;
        run_access(1'b1, 2'd0, 1'b0, 14'h0101, 32'h0000_00A5, 32'h0, 0, 1'b0, o);
        n_checks++;
        if ({o.be, o.wdata, o.addr} !== {4'b0010, 32'hA5A5_A5A5, 12'h040} || o.done_cyc !== 2) begin
            $display("FAIL b2b_sb: got be=%b wdata=%h addr=%h done_cyc=%0d want 0010 a5a5a5a5 040 2",
                     o.be, o.wdata, o.addr, o.done_cyc);
        end else n_pass++;
        run_access(1'b0, 2'd1, 1'b1, 14'h0102, 32'h0, 32'h8000_7FFF, 0, 1'b0, o);
        n_checks++;
        if (o.be !== 4'b1100 || o.rdata !== 32'hFFFF_8000 || o.done_cyc !== 2) begin
            $display("FAIL b2b_lh: got be=%b rdata=%h done_cyc=%0d want 1100 ffff8000 2",
                     o.be, o.rdata, o.done_cyc);
        end else n_pass++;
        go_idle();
    endtask

    task automatic test_random();
        obs_t          o;
        logic          wr, sg, mis;
        logic [1:0]    sz;
        logic [AW-1:0] ad;
        logic [31:0]   wd, rd, exp_rd;
        int            w, exp_done;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            ad = AW'($urandom);
            wd = $urandom;
            rd = $urandom;
            w  = $urandom_range(0, 3);
            run_access(wr, sz, sg, ad, wd, rd, w, 1'b0, o);
            mis      = m_mis(sz, ad);
            exp_done = mis ? 1 : 2 + w;
            exp_rd   = (mis || wr) ? 32'h0 : m_load(sz, sg, ad, rd);
            n_checks++;
            if (o.done_cyc !== exp_done || o.mis !== mis || o.rdata !== exp_rd ||
                o.stall_cnt !== exp_done || o.stall_done !== 1'b0) begin
                $display("FAIL rand_%0d_result: got done_cyc=%0d mis=%b rdata=%h stall_cycles=%0d want %0d %b %h %0d",
                         i, o.done_cyc, o.mis, o.rdata, o.stall_cnt, exp_done, mis, exp_rd, exp_done);
            end else n_pass++;
            n_checks++;
            if (mis) begin
                if (o.req_seen !== 1'b0) begin
                    $display("FAIL rand_%0d_noreq: got req_seen=%b want 0", i, o.req_seen);
                end else n_pass++;
            end else if (o.req_seen !== 1'b1 || o.stable !== 1'b1 || o.we !== wr ||
                         o.be !== m_be(sz, ad) || o.addr !== (AW-2)'(ad >> 2) ||
                         (wr && o.wdata !== m_wdata(sz, wd))) begin
                $display("FAIL rand_%0d_request: got req=%b stable=%b we=%b be=%b addr=%h wdata=%h want 1 1 %b %b %h %h",
                         i, o.req_seen, o.stable, o.we, o.be, o.addr, o.wdata,
                         wr, m_be(sz, ad), (AW-2)'(ad >> 2), m_wdata(sz, wd));
            end else n_pass++;
        end
        go_idle();
    endtask

`ifdef DM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        run_access(1'b0, 2'd2, 1'b0, 14'h0080, 32'h0, 32'hFFFF_FFFF, 1000, 1'b0, o);
        n_checks++;
        if (o.done_cyc !== 5 || o.tmo !== 1'b1 || o.rdata !== 32'h0 || o.req_at_done !== 1'b0) begin
            $display("FAIL timeout_abort: got done_cyc=%0d timeout=%b rdata=%h mem_req=%b want 5 1 0 0",
                     o.done_cyc, o.tmo, o.rdata, o.req_at_done);
        end else n_pass++;
        go_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_word_store();
        test_signed_byte_load();
        test_unsigned_half_load();
        test_misalign();
        test_reset_mid_access();
        test_flush();
        test_back_to_back();
        test_random();
`ifdef DM_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", n_pass, n_checks);
        $fatal(1);
    end

endmodule
